// File: rtl/regbank_wb_arbiter_pkg.sv
// Shared definitions for the register-bank write-back arbiter: default widths,
// the round-robin pointer state type and the hard-wired zero register index.
package regbank_wb_arbiter_pkg;

    localparam int RB_DATA_W = 32;
    localparam int RB_ADDR_W = 5;
    localparam int ZERO_REG  = 0;

    typedef enum logic {
        PRI_ALU = 1'b0,
        PRI_MEM = 1'b1
    } pri_e;

endpackage

// File: rtl/regbank_wb_arbiter_bypass_mux.sv
// One read-port bypass: returns the in-flight write-stage data when it targets
// the port's address, otherwise the bank's read data. Used only with WB_BYPASS_EN.
module wb_bypass_mux
    import regbank_wb_arbiter_pkg::*;
#(
    parameter int DATA_W  = RB_DATA_W,
    parameter int ADDR_W  = RB_ADDR_W,
    parameter bit DROP_R0 = 1'b1
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] bank_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic [DATA_W-1:0] fwd_o
);

    logic is_zero;
    logic hit;

    // Register 0 reads always come from the bank when it is hard-wired.
    assign is_zero = DROP_R0 && (addr_i == ADDR_W'(ZERO_REG));
    assign hit     = wr_en_i && (wr_addr_i == addr_i) && !is_zero;
    assign fwd_o   = hit ? wr_data_i : bank_i;

endmodule

// File: rtl/regbank_wb_arbiter.sv
// Round-robin arbiter sharing the register bank's single write port between the
// ALU and load result paths; WB_BYPASS_EN adds forwarding to the two read ports.
module regbank_wb_arbiter
    import regbank_wb_arbiter_pkg::*;
#(
    parameter int DATA_W  = RB_DATA_W,
    parameter int ADDR_W  = RB_ADDR_W,
    parameter bit DROP_R0 = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_req,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_gnt,
    input  logic              mem_req,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_gnt,
    output logic              write_en,
    output logic [ADDR_W-1:0] reg_wr,
    output logic [DATA_W-1:0] data,
`ifdef WB_BYPASS_EN
    input  logic [ADDR_W-1:0] reg1,
    input  logic [ADDR_W-1:0] reg2,
    input  logic [DATA_W-1:0] reg1_bank,
    input  logic [DATA_W-1:0] reg2_bank,
    output logic [DATA_W-1:0] reg1_fwd,
    output logic [DATA_W-1:0] reg2_fwd,
`endif
    output logic              pri_dbg
);

    pri_e              pri_q, pri_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_rd_q, wr_rd_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              gnt_any;
    logic [ADDR_W-1:0] gnt_rd;
    logic [DATA_W-1:0] gnt_data;

    // Handshake: a requester holds req/rd/data stable until it sees its gnt high
    // in the same cycle; gnt is combinational, never high without req, one-hot.
    always_comb begin
        alu_gnt = 1'b0;
        mem_gnt = 1'b0;
        if (!reset) begin
            if (alu_req && (!mem_req || pri_q == PRI_ALU)) begin
                alu_gnt = 1'b1;
            end else if (mem_req) begin
                mem_gnt = 1'b1;
            end
        end
    end

    assign gnt_any  = alu_gnt || mem_gnt;
    assign gnt_rd   = alu_gnt ? alu_rd : mem_rd;
    assign gnt_data = alu_gnt ? alu_data : mem_data;

    always_comb begin
        pri_d     = pri_q;
        wr_en_d   = 1'b0;
        wr_rd_d   = wr_rd_q;
        wr_data_d = wr_data_q;
        if (gnt_any) begin
            // A granted write to r0 still consumes its turn but never strobes the bank.
            wr_en_d   = !(DROP_R0 && (gnt_rd == ADDR_W'(ZERO_REG)));
            wr_rd_d   = gnt_rd;
            wr_data_d = gnt_data;
            pri_d     = alu_gnt ? PRI_MEM : PRI_ALU;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pri_q     <= PRI_ALU;
            wr_en_q   <= 1'b0;
            wr_rd_q   <= '0;
            wr_data_q <= '0;
        end else begin
            pri_q     <= pri_d;
            wr_en_q   <= wr_en_d;
            wr_rd_q   <= wr_rd_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign write_en = wr_en_q;
    assign reg_wr   = wr_rd_q;
    assign data     = wr_data_q;
    assign pri_dbg  = pri_q;

`ifdef WB_BYPASS_EN
    wb_bypass_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DROP_R0(DROP_R0)) u_fwd1 (
        .addr_i    (reg1),
        .bank_i    (reg1_bank),
        .wr_en_i   (wr_en_q),
        .wr_addr_i (wr_rd_q),
        .wr_data_i (wr_data_q),
        .fwd_o     (reg1_fwd)
    );

    wb_bypass_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DROP_R0(DROP_R0)) u_fwd2 (
        .addr_i    (reg2),
        .bank_i    (reg2_bank),
        .wr_en_i   (wr_en_q),
        .wr_addr_i (wr_rd_q),
        .wr_data_i (wr_data_q),
        .fwd_o     (reg2_fwd)
    );
`endif

endmodule

// File: tb/tb_regbank_wb_arbiter.sv
// Bench for regbank_wb_arbiter: directed scenarios then randomized traffic,
// checked against a turn-taking/bank model; bypass checks only with WB_BYPASS_EN.
module tb_regbank_wb_arbiter;

    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam bit DROP = 1'b1;

    logic          clk = 1'b0;
    logic          reset;
    logic          alu_req, mem_req;
    logic [AW-1:0] alu_rd, mem_rd;
    logic [DW-1:0] alu_data, mem_data;
    logic          alu_gnt, mem_gnt;
    logic          write_en;
    logic [AW-1:0] reg_wr;
    logic [DW-1:0] data;
    logic          pri_dbg;
`ifdef WB_BYPASS_EN
    logic [AW-1:0] reg1, reg2;
    logic [DW-1:0] reg1_bank, reg2_bank, reg1_fwd, reg2_fwd;
    int            sel1 = -1;
`endif

    // Model state: bank contents, pending writes {we, rd, data}, last write-stage values.
    logic [DW-1:0]   bank_m [32];
    logic [AW+DW:0]  exp_q[$];
    logic            exp_we;
    logic [AW-1:0]   hold_rd;
    logic [DW-1:0]   hold_data;
    logic            last_was_alu;
    logic            exp_ag, exp_mg;
    int              checks = 0;
    int              errors = 0;

    always #5 clk = ~clk;

    regbank_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .DROP_R0(DROP)) dut (
        .clk       (clk),
        .reset     (reset),
        .alu_req   (alu_req),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .alu_gnt   (alu_gnt),
        .mem_req   (mem_req),
        .mem_rd    (mem_rd),
        .mem_data  (mem_data),
        .mem_gnt   (mem_gnt),
        .write_en  (write_en),
        .reg_wr    (reg_wr),
        .data      (data),
`ifdef WB_BYPASS_EN
        .reg1      (reg1),
        .reg2      (reg2),
        .reg1_bank (reg1_bank),
        .reg2_bank (reg2_bank),
        .reg1_fwd  (reg1_fwd),
        .reg2_fwd  (reg2_fwd),
`endif
        .pri_dbg   (pri_dbg)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

`ifdef WB_BYPASS_EN
    function automatic logic [DW-1:0] fwd_model(input logic [AW-1:0] a, input logic [DW-1:0] bank);
        if (exp_we && hold_rd == a && !(DROP && a == '0)) return hold_data;
        return bank;
    endfunction
`endif

    // One clock: check outputs mid-cycle, then advance the model across the edge.
    task automatic tick();
        logic [AW+DW:0] e;
        logic [AW-1:0]  g_rd;
        @(negedge clk);
        if (exp_q.size() != 0) begin
            e         = exp_q.pop_front();
            exp_we    = e[AW+DW];
            hold_rd   = e[AW+DW-1:DW];
            hold_data = e[DW-1:0];
        end else begin
            exp_we = 1'b0;
        end
        // The requester that was not served last has precedence under contention.
        exp_ag = !reset && alu_req && (!mem_req || !last_was_alu);
        exp_mg = !reset && mem_req && (!alu_req || last_was_alu);
        chk("write_en", 32'(write_en), 32'(exp_we));
        chk("reg_wr",   32'(reg_wr),   32'(hold_rd));
        chk("data",     data,          hold_data);
        chk("alu_gnt",  32'(alu_gnt),  32'(exp_ag));
        chk("mem_gnt",  32'(mem_gnt),  32'(exp_mg));
        chk("pointer",  32'(pri_dbg),  32'(last_was_alu));
`ifdef WB_BYPASS_EN
        chk("reg1_fwd", reg1_fwd, fwd_model(reg1, reg1_bank));
        chk("reg2_fwd", reg2_fwd, fwd_model(reg2, reg2_bank));
`endif
        @(posedge clk);
        #1;
        if (exp_we) bank_m[hold_rd] = hold_data;
        if (reset) begin
            exp_q.delete();
            hold_rd      = '0;
            hold_data    = '0;
            last_was_alu = 1'b0;
        end else if (exp_ag || exp_mg) begin
            g_rd = exp_ag ? alu_rd : mem_rd;
            exp_q.push_back({!(DROP && g_rd == '0), g_rd, exp_ag ? alu_data : mem_data});
            last_was_alu = exp_ag;
        end
`ifdef WB_BYPASS_EN
        reg1      = (sel1 >= 0) ? AW'(sel1) : AW'($urandom_range(0, 31));
        reg2      = AW'($urandom_range(0, 31));
        reg1_bank = bank_m[reg1];
        reg2_bank = bank_m[reg2];
`endif
    endtask

    task automatic retire();
        if (exp_ag) alu_req = 1'b0;
        if (exp_mg) mem_req = 1'b0;
    endtask

    task automatic set_alu(input logic [AW-1:0] rd, input logic [DW-1:0] d);
        alu_req  = 1'b1;
        alu_rd   = rd;
        alu_data = d;
    endtask

    task automatic set_mem(input logic [AW-1:0] rd, input logic [DW-1:0] d);
        mem_req  = 1'b1;
        mem_rd   = rd;
        mem_data = d;
    endtask

    initial begin
        reset = 1'b1;
        alu_req = 1'b0; alu_rd = '0; alu_data = '0;
        mem_req = 1'b0; mem_rd = '0; mem_data = '0;
        exp_we = 1'b0; hold_rd = '0; hold_data = '0;
        last_was_alu = 1'b0; exp_ag = 1'b0; exp_mg = 1'b0;
        for (int i = 0; i < 32; i++) bank_m[i] = '0;
`ifdef WB_BYPASS_EN
        reg1 = '0; reg2 = '0; reg1_bank = '0; reg2_bank = '0;
`endif

        // Reset for two cycles, then idle.
        tick(); tick();
        reset = 1'b0;
        tick(); tick();

        // Lone ALU write.
        set_alu(5'd5, 32'd4231421);
        tick(); retire();
        tick(); tick();

        // Continuous contention starting from reset.
        set_alu(5'd3, 32'hA);
        set_mem(5'd4, 32'hB);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        alu_req = 1'b0; mem_req = 1'b0;
        tick(); tick();

        // Load to r0 is granted but dropped.
        set_alu(5'd1, 32'h1234);
        tick(); retire();
        set_mem(5'd0, 32'hDEAD);
        tick(); retire();
        tick(); tick();

        // Reset in the cycle the ALU would be granted r7; request is held across it.
        set_alu(5'd7, 32'h77);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick(); retire();
        tick(); tick();

`ifdef WB_BYPASS_EN
        // Forward an in-flight write to r5 over a stale bank value.
        bank_m[5] = 32'h11;
        sel1 = 5;
        set_alu(5'd5, 32'h55);
        tick(); retire();
        tick(); tick();
        sel1 = -1;
`endif

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            if (exp_ag || !alu_req) begin
                alu_req  = ($urandom_range(0, 3) != 0);
                alu_rd   = AW'($urandom_range(0, 31));
                alu_data = $urandom;
            end
            if (exp_mg || !mem_req) begin
                mem_req  = ($urandom_range(0, 3) != 0);
                mem_rd   = AW'($urandom_range(0, 31));
                mem_data = $urandom;
            end
            reset = ($urandom_range(0, 39) == 0);
            tick();
        end
        reset = 1'b0;
        alu_req = 1'b0; mem_req = 1'b0;
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
